// File: rtl/rd_fifo_byte_streamer_pkg.sv
// Shared SDRAM read-path parameters: word width, bytes per word, streamer state encoding.
package rd_fifo_byte_streamer_pkg;

    localparam int SDRAM_DSIZE          = 16;
    localparam int SDRAM_BYTES_PER_WORD = SDRAM_DSIZE / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_READ = 3'd3,
        ST_CAP  = 3'd4,
        ST_SEND = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    function automatic int sdram_bytes_per_word(input int dsize);
        return dsize / 8;
    endfunction

endpackage

// File: rtl/rd_fifo_byte_streamer.sv
// Drains Xfer_len words from the read FIFO and streams them MSB-first as bytes.
// Latency: Done 2 cycles after Start for an empty transfer; 3 cycles/word overhead; Tx held until Tx_ready.
module rd_fifo_byte_streamer
    import rd_fifo_byte_streamer_pkg::*;
#(
    parameter int DSIZE = SDRAM_DSIZE,
    parameter int LEN_W = 24
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [LEN_W-1:0] Xfer_len,
    output logic             Rd_load,
    output logic             Rd_en,
    input  logic [DSIZE-1:0] Rd_data,
    input  logic             Rd_empty,
    output logic [7:0]       Tx_data,
    output logic             Tx_valid,
    input  logic             Tx_ready,
    output logic             Busy,
    output logic             Done
);

    localparam int BPW   = sdram_bytes_per_word(DSIZE);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BPW - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DSIZE-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_LOAD;
            ST_LOAD: state_d = (cnt_q == '0) ? ST_FIN : ST_WAIT;
            ST_WAIT: if (!Rd_empty) state_d = ST_READ;
            // Read is only issued against a non-empty FIFO; otherwise fall back and wait.
            ST_READ: state_d = Rd_empty ? ST_WAIT : ST_CAP;
            ST_CAP:  state_d = ST_SEND;
            ST_SEND: begin
                if (Tx_ready && (idx_q == '0)) begin
                    state_d = (cnt_q != '0) ? ST_WAIT : ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (Start) cnt_d = Xfer_len;
            ST_READ: if (!Rd_empty) cnt_d = cnt_q - LEN_W'(1);
            ST_CAP: begin
                shift_d = Rd_data;
                idx_d   = IDX_TOP;
            end
            ST_SEND: begin
                // Shifting keeps the outgoing byte in the top slot, so Tx_data is a plain flop slice.
                if (Tx_ready) begin
                    shift_d = shift_q << 8;
                    if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        Rd_load  = (state_q == ST_LOAD);
        Rd_en    = (state_q == ST_READ) && !Rd_empty;
        Tx_valid = (state_q == ST_SEND);
        Busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
        Done     = (state_q == ST_FIN);
    end

    assign Tx_data = shift_q[DSIZE-1 -: 8];

endmodule

// File: tb/tb_rd_fifo_byte_streamer.sv
// Directed bench for rd_fifo_byte_streamer with a FIFO model and a byte-stream scoreboard.
module tb_rd_fifo_byte_streamer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Start = 1'b0;
    logic [23:0] Xfer_len = '0;
    logic        Rd_load;
    logic        Rd_en;
    logic [15:0] Rd_data = '0;
    logic        Rd_empty;
    logic [7:0]  Tx_data;
    logic        Tx_valid;
    logic        Tx_ready = 1'b0;
    logic        Busy;
    logic        Done;

    always #5 Clk = ~Clk;

    rd_fifo_byte_streamer #(.DSIZE(16), .LEN_W(24)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Xfer_len(Xfer_len),
        .Rd_load(Rd_load), .Rd_en(Rd_en), .Rd_data(Rd_data), .Rd_empty(Rd_empty),
        .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
        .Busy(Busy), .Done(Done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // FIFO model: clear on Rd_load, pop on Rd_en with one-cycle read latency
    logic [15:0] fifo_q[$];
    int          fifo_cnt = 0;
    logic        force_empty = 1'b0;
    logic        push_vld = 1'b0;
    logic [15:0] push_dat = '0;

    assign Rd_empty = force_empty || (fifo_cnt == 0);

    always @(posedge Clk) begin
        if (Rd_load) begin
            fifo_q.delete();
        end else begin
            if (Rd_en && fifo_q.size() > 0) Rd_data <= fifo_q.pop_front();
            if (push_vld) fifo_q.push_back(push_dat);
        end
        fifo_cnt <= fifo_q.size();
    end

    logic rdy_tog = 1'b0;
    logic rdy_lvl = 1'b1;
    always @(posedge Clk) begin
        #1;
        if (rdy_tog) Tx_ready = !Tx_ready;
        else         Tx_ready = rdy_lvl;
    end

    // Scoreboard: every pushed word must come out as its bytes, MSB first, in order
    logic [7:0] exp_q[$];
    logic [7:0] byte_log[$];
    bit   xfer_on = 0, acc_last = 0, stall_last = 0;
    logic [7:0] last_data = '0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, rd_en_cnt = 0, tx_valid_cnt = 0;
    int last_rd_cyc = 0, prev_rd_cyc = 0;

    always @(negedge Clk) begin
        bit acc;
        cyc++;
        if (!Rst_n) begin
            chk("rst_rd_load", Rd_load, 0);
            chk("rst_rd_en", Rd_en, 0);
            chk("rst_tx_valid", Tx_valid, 0);
            chk("rst_tx_data", Tx_data, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            xfer_on = 0; acc_last = 0; stall_last = 0;
            exp_q.delete();
        end else begin
            if (push_vld) begin
                exp_q.push_back(push_dat[15:8]);
                exp_q.push_back(push_dat[7:0]);
            end
            chk("rd_load", Rd_load, acc_last);
            chk("busy", Busy, xfer_on && !Done);
            if (Done) begin
                chk("done_in_xfer", xfer_on, 1);
                done_cnt++;
                done_cyc = cyc;
            end
            chk("rd_en_while_empty", Rd_en && Rd_empty, 0);
            if (!xfer_on) chk("tx_valid_idle", Tx_valid, 0);
            if (stall_last) begin
                chk("tx_valid_hold", Tx_valid, 1);
                chk("tx_data_hold", Tx_data, last_data);
            end
            if (Rd_en) begin
                rd_en_cnt++;
                prev_rd_cyc = last_rd_cyc;
                last_rd_cyc = cyc;
            end
            if (Tx_valid) tx_valid_cnt++;
            if (Tx_valid && Tx_ready) begin
                if (exp_q.size() == 0) chk("tx_unexpected_byte", 1, 0);
                else                   chk("tx_byte", Tx_data, exp_q.pop_front());
                byte_log.push_back(Tx_data);
            end
            stall_last = Tx_valid && !Tx_ready;
            last_data  = Tx_data;
            acc = Start && !xfer_on;
            if (acc) start_cyc = cyc;
            if (Done) xfer_on = 0;
            if (acc) xfer_on = 1;
            acc_last = acc;
        end
    end

    task automatic start_xfer(input logic [23:0] len);
        @(posedge Clk); #1;
        Xfer_len = len;
        Start    = 1'b1;
        @(posedge Clk); #1;
        Start    = 1'b0;
    endtask

    task automatic wait_load();
        bit seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Rd_load) begin seen = 1; break; end
        end
        chk("rd_load_seen", seen, 1);
    endtask

    task automatic push_word(input logic [15:0] w);
        @(posedge Clk); #1;
        push_vld = 1'b1;
        push_dat = w;
        @(posedge Clk); #1;
        push_vld = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        bit seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge Clk);
            if (Done) begin seen = 1; break; end
        end
        #1;
        chk(nm, seen, 1);
    endtask

    task automatic chk_bytes(input string nm, input int base, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                             input int n);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, byte_log.size() - base, n);
        if (byte_log.size() >= base + n)
            for (int i = 0; i < n; i++) chk(nm, byte_log[base + i], e[i]);
    endtask

    initial begin
        int b0, r0, d0, v0;
        #2 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);

        // Two words, free-running transmitter
        b0 = byte_log.size(); r0 = rd_en_cnt; d0 = done_cnt;
        start_xfer(24'd2);
        wait_load();
        push_word(16'h1234);
        push_word(16'hABCD);
        wait_done("t1_done", 60);
        chk_bytes("t1_bytes", b0, 8'h12, 8'h34, 8'hAB, 8'hCD, 4);
        chk("t1_rd_en", rd_en_cnt - r0, 2);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_word_gap", last_rd_cyc - prev_rd_cyc, 5);

        // Zero-length transfer
        r0 = rd_en_cnt; v0 = tx_valid_cnt; d0 = done_cnt;
        start_xfer(24'd0);
        wait_done("t2_done", 10);
        chk("t2_done_latency", done_cyc - start_cyc, 2);
        chk("t2_rd_en", rd_en_cnt - r0, 0);
        chk("t2_tx_valid", tx_valid_cnt - v0, 0);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // FIFO reported empty for 20 cycles
        b0 = byte_log.size(); r0 = rd_en_cnt;
        force_empty = 1'b1;
        start_xfer(24'd1);
        wait_load();
        push_word(16'hBEEF);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("t3_busy_held", Busy, 1);
        end
        chk("t3_no_rd_en", rd_en_cnt - r0, 0);
        @(posedge Clk); #1;
        force_empty = 1'b0;
        wait_done("t3_done", 30);
        chk("t3_rd_en", rd_en_cnt - r0, 1);
        chk_bytes("t3_bytes", b0, 8'hBE, 8'hEF, 8'h00, 8'h00, 2);

        // Transmitter toggling ready every cycle
        b0 = byte_log.size();
        rdy_tog = 1'b1;
        start_xfer(24'd1);
        wait_load();
        push_word(16'h5AA5);
        wait_done("t4_done", 40);
        rdy_tog = 1'b0;
        chk_bytes("t4_bytes", b0, 8'h5A, 8'hA5, 8'h00, 8'h00, 2);

        // Second Start while busy is ignored
        b0 = byte_log.size(); r0 = rd_en_cnt; d0 = done_cnt;
        start_xfer(24'd3);
        wait_load();
        push_word(16'h0102);
        push_word(16'h0304);
        push_word(16'h0506);
        start_xfer(24'd7);
        wait_done("t5_done", 80);
        repeat (4) @(negedge Clk);
        chk("t5_rd_en", rd_en_cnt - r0, 3);
        chk("t5_done_cnt", done_cnt - d0, 1);
        chk("t5_byte_count", byte_log.size() - b0, 6);
        chk("t5_busy_after", Busy, 0);

        // Reset in the middle of SEND
        d0 = done_cnt;
        rdy_lvl = 1'b0;
        start_xfer(24'd2);
        wait_load();
        push_word(16'hC3C3);
        push_word(16'h3C3C);
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge Clk);
                if (Tx_valid) begin seen = 1; break; end
            end
            chk("t6_in_send", seen, 1);
        end
        #1 Rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_valid", Tx_valid, 0);
        chk("t6_rst_tx_data", Tx_data, 0);
        chk("t6_rst_busy", Busy, 0);
        repeat (3) @(negedge Clk);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        rdy_lvl = 1'b1;
        repeat (5) @(negedge Clk);
        chk("t6_no_done", done_cnt - d0, 0);
        b0 = byte_log.size(); r0 = rd_en_cnt;
        start_xfer(24'd1);
        wait_load();
        push_word(16'h9A7E);
        wait_done("t6_done", 30);
        chk_bytes("t6_bytes", b0, 8'h9A, 8'h7E, 8'h00, 8'h00, 2);
        chk("t6_rd_en", rd_en_cnt - r0, 1);

        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rd_fifo_byte_streamer.md
RD_FIFO_BYTE_STREAMER -- requirements
Module: rd_fifo_byte_streamer

Interface
REQ-001 SHALL have parameter DSIZE, default 16, read-FIFO word width in bits (multiple of 8).
REQ-002 SHALL have parameter LEN_W, default 24, width of the word-count field.
REQ-003 SHALL have port Clk  in  1  system clock; the read-FIFO Rd_clk domain.
REQ-004 SHALL have port Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  in  1  single-cycle request to begin a transfer.
REQ-006 SHALL have port Xfer_len  in  LEN_W  number of DSIZE words to stream; sampled on accepted Start.
REQ-007 SHALL have port Rd_load  out  1  read-FIFO clear pulse.
REQ-008 SHALL have port Rd_en  out  1  read-FIFO read request.
REQ-009 SHALL have port Rd_data  in  DSIZE  read-FIFO output word; valid one cycle after Rd_en.
REQ-010 SHALL have port Rd_empty  in  1  read-FIFO empty flag.
REQ-011 SHALL have port Tx_data  out  8  byte to the serial transmitter.
REQ-012 SHALL have port Tx_valid  out  1  Tx_data valid.
REQ-013 SHALL have port Tx_ready  in  1  transmitter accepts the byte in a cycle with Tx_valid high.
REQ-014 SHALL have port Busy  out  1  high from accepted Start until Done.
REQ-015 SHALL have port Done  out  1  single-cycle pulse at transfer end.

Function
REQ-016 SHALL implement these FSM states: IDLE, LOAD, WAIT, READ, CAP, SEND, FIN.
REQ-017 IDLE: on Start, latch Xfer_len into the remaining-word counter and go to LOAD; Busy rises in the next cycle.
REQ-018 LOAD: assert Rd_load for exactly 1 cycle; if the counter is 0, go to FIN, else go to WAIT.
REQ-019 WAIT: stay while Rd_empty=1; when Rd_empty=0, go to READ.
REQ-020 READ: assert Rd_en for exactly 1 cycle, decrement the counter, go to CAP.
REQ-021 CAP: latch Rd_data into the shift register, set byte index to DSIZE/8-1, go to SEND.
REQ-022 SEND: Tx_valid=1 and Tx_data = the byte at the current index; bytes go MSB first.
REQ-023 SEND: on a Tx_ready cycle, move to the next lower byte; after byte 0 is accepted, go to WAIT if the counter is nonzero, else go to FIN.
REQ-024 While Tx_valid=1 and Tx_ready=0, Tx_data SHALL hold stable and Tx_valid SHALL stay high; it never drops without acceptance.
REQ-025 FIN: pulse Done for 1 cycle, clear Busy in the same cycle, return to IDLE.
REQ-026 Rd_en SHALL never be asserted while Rd_empty=1; there is at most one Rd_en per word and no pipelined reads.
REQ-027 Start SHALL be ignored while Busy=1 or in FIN.
REQ-028 The counter SHALL be an unsigned LEN_W bit value; maximum 2^LEN_W-1 words, no wrap.
REQ-029 Back-to-back operation: Tx_ready held at 1 SHALL give one byte per cycle in SEND; per-word overhead is 3 cycles (WAIT/READ/CAP) when the FIFO is non-empty.
REQ-030 Tx_data SHALL be registered; there is no combinational path from Tx_ready to Tx_data.

Reset
REQ-031 Rst_n low SHALL asynchronously force: state IDLE, Rd_load=0, Rd_en=0, Tx_valid=0, Tx_data=0, Busy=0, Done=0, counter=0, shift register=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no Done pulse; the first Start after reset release behaves as a fresh transfer.

Structure
REQ-033 The state encoding and the bytes-per-word constant (DSIZE/8) SHALL live in the shared SDRAM parameter package alongside DSIZE.
REQ-034 The design SHALL be a single module with no sub-modules; the FIFO and transmitter are external.

Verification
REQ-035 Xfer_len=2, FIFO holding 0x1234, 0xABCD, Tx_ready=1 -> Tx bytes 12,34,AB,CD; 2 Rd_en pulses; 1 Done.
REQ-036 Xfer_len=0 -> Rd_load pulse, then Done 2 cycles after Start; no Rd_en, no Tx_valid.
REQ-037 Xfer_len=1, Rd_empty=1 for 20 cycles then 0 -> Rd_en only after Rd_empty falls; Busy high throughout.
REQ-038 Tx_ready toggling 0/1 each cycle on word 0x5AA5 -> Tx_data stable through stalls; exactly bytes 5A, A5 delivered.
REQ-039 Start pulsed again mid-transfer with Xfer_len=7 -> ignored; original length completes.
REQ-040 Rst_n asserted during SEND -> all outputs 0 immediately; no Done; a new Start runs normally.
